// File: rtl/inv_mixcol_seq_if.sv
// rtl/inv_mixcol_seq_if.sv - handshake bundle for inv_mixcol_seq; fwd present only with INV_MIXCOL_FWD_EN
interface inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ip;
  logic         enable;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] op;
`ifdef INV_MIXCOL_FWD_EN
  logic         fwd;

  modport master (
    output in_valid, ip, enable, fwd, out_ready,
    input  in_ready, out_valid, op
  );
  modport slave (
    input  in_valid, ip, enable, fwd, out_ready,
    output in_ready, out_valid, op
  );
`else
  modport master (
    output in_valid, ip, enable, out_ready,
    input  in_ready, out_valid, op
  );
  modport slave (
    input  in_valid, ip, enable, out_ready,
    output in_ready, out_valid, op
  );
`endif
endinterface

// File: rtl/inv_mixcol_seq.sv
// rtl/inv_mixcol_seq.sv - iterative AES InvMixColumns, one column per clock; INV_MIXCOL_FWD_EN adds forward matrix
module inv_mixcol_seq (
  input  logic         clk,
  input  logic         rst_n,
  inv_mixcol_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, next_state;
  logic [1:0]   cnt;
  logic [127:0] work_q;
  logic [127:0] res_q;
  logic         accept;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  col;
  logic [31:0]  mix_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Row 0 sits in the top byte of a column.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {me(s0) ^ mb(s1) ^ md(s2) ^ m9(s3),
            m9(s0) ^ me(s1) ^ mb(s2) ^ md(s3),
            md(s0) ^ m9(s1) ^ me(s2) ^ mb(s3),
            mb(s0) ^ md(s1) ^ m9(s2) ^ me(s3)};
  endfunction

`ifdef INV_MIXCOL_FWD_EN
  logic fwd_q;

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
            xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
  endfunction
`endif

  assign col = work_q[{cnt, 5'd0} +: 32];

`ifdef INV_MIXCOL_FWD_EN
  assign mix_out = fwd_q ? fwd_col(col) : inv_col(col);
`else
  assign mix_out = inv_col(col);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          next_state = bus.enable ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == 2'd3) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      work_q <= '0;
      res_q  <= '0;
`ifdef INV_MIXCOL_FWD_EN
      fwd_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        work_q <= bus.ip;
        cnt    <= 2'd0;
`ifdef INV_MIXCOL_FWD_EN
        fwd_q  <= bus.fwd;
`endif
        if (!bus.enable) begin
          res_q <= bus.ip;
        end
      end
      if (state == BUSY) begin
        res_q[{cnt, 5'd0} +: 32] <= mix_out;
        cnt <= (cnt == 2'd3) ? 2'd0 : cnt + 2'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.op        = res_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// tb/tb_inv_mixcol_seq.sv - self-checking bench for inv_mixcol_seq
module tb_inv_mixcol_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_mixcol_seq_if bus ();

  inv_mixcol_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [127:0] sb[$];

  typedef struct {
    logic [127:0] ip;
    logic         en;
    logic         fwd;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] ip, input logic en, input logic f);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.ip       = ip;
    bus.enable   = en;
`ifdef INV_MIXCOL_FWD_EN
    bus.fwd      = f;
`else
    if (f) $display("note: fwd requested without INV_MIXCOL_FWD_EN");
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ip       = ~ip;
    bus.enable   = ~en;
  endtask

  task automatic send(input logic [127:0] ip, input logic en, input logic f, input logic [127:0] exp);
    drive(ip, en, f);
    sb.push_back(exp);
  endtask

  task automatic collect(input string name, input int lat_exp);
    int lat;
    logic [127:0] exp;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(lat_exp));
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_scoreboard: got empty queue required one entry", name);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    check({name, "_op"}, bus.op, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_in_ready_after"}, 128'(bus.in_ready), 128'(1));
    check({name, "_out_valid_after"}, 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] blk_a, blk_b, exp_a, exp_b;
    int seen;

    bus.in_valid  = 1'b0;
    bus.ip        = '0;
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef INV_MIXCOL_FWD_EN
    bus.fwd       = 1'b0;
`endif

    vecs.push_back('{128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b0,
                     128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 4});
    vecs.push_back('{128'h01010101_c6c6c6c6_01010101_c6c6c6c6, 1'b1, 1'b0,
                     128'h01010101_c6c6c6c6_01010101_c6c6c6c6, 4});
    vecs.push_back('{128'h00000000_00000000_00000000_8e4da1bc, 1'b1, 1'b0,
                     128'h00000000_00000000_00000000_db135345, 4});
    vecs.push_back('{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b1, 1'b0,
                     128'hffffffff_ffffffff_ffffffff_ffffffff, 4});
    vecs.push_back('{128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b0, 1'b0,
                     128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 0});
    vecs.push_back('{128'h0123456789abcdef_fedcba9876543210, 1'b0, 1'b0,
                     128'h0123456789abcdef_fedcba9876543210, 0});
`ifdef INV_MIXCOL_FWD_EN
    vecs.push_back('{128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 1'b1, 1'b1,
                     128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 4});
`endif

    #12;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_op", bus.op, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].ip, vecs[i].en, vecs[i].fwd, vecs[i].exp);
      collect($sformatf("vec%0d", i), vecs[i].lat);
    end

    // Back-pressure: new data offered while a result is held must be ignored.
    blk_a = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    exp_a = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    blk_b = 128'h00000000_8e4da1bc_01010101_00000000;
    exp_b = 128'h00000000_db135345_01010101_00000000;
    send(blk_a, 1'b1, 1'b0, exp_a);
    seen = 0;
    while (!bus.out_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.ip       = blk_b;
      bus.enable   = 1'b1;
      @(negedge clk);
      check($sformatf("bp_op_c%0d", c), bus.op, exp_a);
      check($sformatf("bp_in_ready_c%0d", c), 128'(bus.in_ready), 128'(0));
      check($sformatf("bp_out_valid_c%0d", c), 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid = 1'b0;
    collect("bp_first", 0);
    send(blk_b, 1'b1, 1'b0, exp_b);
    collect("bp_second", 4);

    // Reset in BUSY after two columns drops the block.
    drive(blk_a, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_op", bus.op, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_output", 128'(seen), 128'(0));
    check("midrst_op_after", bus.op, 128'h0);

    send(blk_b, 1'b1, 1'b0, exp_b);
    collect("post_rst", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
